// File: rtl/router_pkg.sv
// Shared types and constants for the router destination-side reader.
package router_pkg;

    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_W    = 6;
    localparam int TIMEOUT_CYC  = 30;
    localparam int RD_DELAY_MAX = 25;
    localparam int DLY_W        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HDR,
        ST_HWAIT,
        ST_BODY,
        ST_LAST,
        ST_DONE
    } rdr_state_t;

endpackage

// File: rtl/router_sat_cnt.sv
// Saturating event counter with synchronous clear.
module router_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + WIDTH'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/router_dest_reader.sv
// Destination-side packet consumer: reads one router output FIFO, reassembles
// header/payload/parity, checks parity and keeps good/error packet counts.
module router_dest_reader
    import router_pkg::*;
#(
    parameter int RD_DELAY = 0,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_out,
    input  logic [7:0]            data_out,
    input  logic                  soft_reset,
    output logic                  read_enb,
    output logic [7:0]            pld_data,
    output logic                  pld_valid,
    output logic                  pkt_done,
    output logic [HDR_ADDR_W-1:0] pkt_addr,
    output logic [HDR_LEN_W-1:0]  pkt_len,
    output logic                  parity_err,
    output logic                  pkt_drop,
    output logic [CNT_W-1:0]      good_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    rdr_state_t            state_reg, state_next;
    logic [DLY_W-1:0]      dly_reg, dly_next;
    logic [HDR_LEN_W:0]    rem_reg, rem_next;
    logic [HDR_LEN_W-1:0]  pay_reg, pay_next;
    logic [7:0]            acc_reg, acc_next;
    logic [HDR_ADDR_W-1:0] hdr_addr_reg, hdr_addr_next;
    logic [HDR_LEN_W-1:0]  hdr_len_reg, hdr_len_next;
    logic                  cap_v_reg;
    logic                  abort_reg;
    logic [7:0]            pld_data_reg;
    logic                  pld_valid_reg, pkt_done_reg, pkt_drop_reg, parity_err_reg;
    logic [HDR_ADDR_W-1:0] pkt_addr_reg;
    logic [HDR_LEN_W-1:0]  pkt_len_reg;
    logic                  rd_state, pld_evt, done_evt, perr_evt, abort_evt;

    assign rd_state  = (state_reg == ST_HDR) || (state_reg == ST_BODY);
    assign read_enb  = rd_state & valid_out;
    assign abort_evt = soft_reset && (state_reg != ST_IDLE);

    always_comb begin
        state_next    = state_reg;
        dly_next      = dly_reg;
        rem_next      = rem_reg;
        pay_next      = pay_reg;
        acc_next      = acc_reg;
        hdr_addr_next = hdr_addr_reg;
        hdr_len_next  = hdr_len_reg;
        pld_evt       = 1'b0;
        done_evt      = 1'b0;
        perr_evt      = 1'b0;
        if (abort_evt) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (valid_out) begin
                        if (RD_DELAY == 0) begin
                            state_next = ST_HDR;
                        end else begin
                            state_next = ST_DELAY;
                            dly_next   = DLY_W'(RD_DELAY);
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_reg == DLY_W'(1)) state_next = ST_HDR;
                    else                      dly_next   = dly_reg - DLY_W'(1);
                end
                ST_HDR: begin
                    if (read_enb) state_next = ST_HWAIT;
                end
                ST_HWAIT: begin
                    // Header byte is on data_out now; seed parity and byte counts.
                    hdr_addr_next = data_out[HDR_ADDR_W-1:0];
                    hdr_len_next  = data_out[7:HDR_ADDR_W];
                    acc_next      = data_out;
                    rem_next      = {1'b0, data_out[7:HDR_ADDR_W]} + (HDR_LEN_W+1)'(1);
                    pay_next      = data_out[7:HDR_ADDR_W];
                    state_next    = ST_BODY;
                end
                ST_BODY: begin
                    if (read_enb) begin
                        rem_next = rem_reg - (HDR_LEN_W+1)'(1);
                        if (rem_reg == (HDR_LEN_W+1)'(1)) state_next = ST_LAST;
                    end
                    // The final read is the parity byte, so only pay_reg bytes are payload.
                    if (cap_v_reg && (pay_reg != '0)) begin
                        pay_next = pay_reg - HDR_LEN_W'(1);
                        acc_next = acc_reg ^ data_out;
                        pld_evt  = 1'b1;
                    end
                end
                ST_LAST: begin
                    if (cap_v_reg) begin
                        done_evt   = 1'b1;
                        perr_evt   = (acc_reg != data_out);
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            dly_reg        <= '0;
            rem_reg        <= '0;
            pay_reg        <= '0;
            acc_reg        <= '0;
            hdr_addr_reg   <= '0;
            hdr_len_reg    <= '0;
            cap_v_reg      <= 1'b0;
            abort_reg      <= 1'b0;
            pld_data_reg   <= '0;
            pld_valid_reg  <= 1'b0;
            pkt_done_reg   <= 1'b0;
            pkt_drop_reg   <= 1'b0;
            pkt_addr_reg   <= '0;
            pkt_len_reg    <= '0;
            parity_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dly_reg        <= dly_next;
            rem_reg        <= rem_next;
            pay_reg        <= pay_next;
            acc_reg        <= acc_next;
            hdr_addr_reg   <= hdr_addr_next;
            hdr_len_reg    <= hdr_len_next;
            cap_v_reg      <= read_enb;
            abort_reg      <= abort_evt;
            pkt_drop_reg   <= abort_reg;
            pld_valid_reg  <= pld_evt;
            pkt_done_reg   <= done_evt;
            if (pld_evt) pld_data_reg <= data_out;
            if (done_evt) begin
                pkt_addr_reg   <= hdr_addr_reg;
                pkt_len_reg    <= hdr_len_reg;
                parity_err_reg <= perr_evt;
            end
        end
    end

    // Index 0 counts good packets, index 1 counts parity errors and drops.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = done_evt & ~perr_evt;
    assign cnt_inc[1] = (done_evt & perr_evt) | abort_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        router_sat_cnt #(.WIDTH(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (cnt_inc[gi]),
            .clr (1'b0),
            .cnt (cnt_val[gi])
        );
    end

    assign good_cnt   = cnt_val[0];
    assign err_cnt    = cnt_val[1];
    assign pld_data   = pld_data_reg;
    assign pld_valid  = pld_valid_reg;
    assign pkt_done   = pkt_done_reg;
    assign pkt_drop   = pkt_drop_reg;
    assign pkt_addr   = pkt_addr_reg;
    assign pkt_len    = pkt_len_reg;
    assign parity_err = parity_err_reg;

    rd_delay_legal: assert property (@(posedge clk) disable iff (!rst)
        (RD_DELAY <= RD_DELAY_MAX) && (RD_DELAY_MAX + 1 < TIMEOUT_CYC));

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: FIFO model, packet table and scoreboard.
module tb_router_dest_reader;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_out = 1'b0;
    logic [7:0]    data_out = 8'h00;
    logic          soft_reset = 1'b0;
    logic          read_enb;
    logic [7:0]    pld_data;
    logic          pld_valid, pkt_done, parity_err, pkt_drop;
    logic [1:0]    pkt_addr;
    logic [5:0]    pkt_len;
    logic [CW-1:0] good_cnt, err_cnt;

    router_dest_reader #(.RD_DELAY(0), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .soft_reset (soft_reset),
        .read_enb   (read_enb),
        .pld_data   (pld_data),
        .pld_valid  (pld_valid),
        .pkt_done   (pkt_done),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .parity_err (parity_err),
        .pkt_drop   (pkt_drop),
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  addr;
        logic [5:0]  len;
        logic [31:0] pld;
        logic        flip;
        int          exp_good;
        int          exp_err;
    } vec_t;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       perr;
        int         cyc;
    } done_t;

    logic [7:0] fifo [$];
    logic [7:0] pld_q [$];
    done_t      done_q [$];
    int         drop_q [$];
    logic       stall = 1'b0;
    logic       drv_rd;
    done_t      mon_rec;
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_good = 0;
    int         exp_err = 0;
    vec_t       vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Queue the packet bytes in the FIFO model and the expected results.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic [31:0] p,
                            input logic flip, input int extra);
        logic [7:0] h, par, b;
        done_t r;
        h = {l, a};
        par = h;
        fifo.push_back(h);
        for (int i = 0; i < int'(l); i++) begin
            b = p[8*(i%4) +: 8];
            fifo.push_back(b);
            pld_q.push_back(b);
            par ^= b;
        end
        fifo.push_back(par ^ {7'd0, flip});
        r.addr = a;
        r.len  = l;
        r.perr = flip;
        r.cyc  = cyc + 6 + int'(l) + extra;
        done_q.push_back(r);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((done_q.size() != 0 || drop_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout pending_done=%0d pending_drop=%0d required 0", done_q.size(), drop_q.size());
        end
        repeat (2) @(negedge clk);
        chk("pld_left", pld_q.size(), 0);
    endtask

    // FIFO model: a read seen mid-cycle is accepted at the next edge and
    // its byte is presented during the following cycle.
    initial begin
        forever begin
            @(negedge clk);
            drv_rd = read_enb;
            @(posedge clk);
            #1;
            if (drv_rd && fifo.size() != 0) data_out = fifo.pop_front();
            valid_out = (fifo.size() != 0) && !stall;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (pld_valid) begin
                    if (pld_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pld_unexpected actual=%0h required none", pld_data);
                    end else begin
                        chk("pld_data", pld_data, pld_q.pop_front());
                    end
                end
                if (pkt_done) begin
                    if (done_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL done_unexpected actual=1 required 0 cyc=%0d", cyc);
                    end else begin
                        mon_rec = done_q.pop_front();
                        chk("done_cyc", cyc, mon_rec.cyc);
                        chk("pkt_addr", pkt_addr, mon_rec.addr);
                        chk("pkt_len", pkt_len, mon_rec.len);
                        chk("parity_err", parity_err, mon_rec.perr);
                        if (mon_rec.perr) exp_err = sat_inc(exp_err);
                        else              exp_good = sat_inc(exp_good);
                        chk("good_cnt", good_cnt, exp_good);
                        chk("err_cnt", err_cnt, exp_err);
                        $display("pkt done cyc=%0d addr=%0d len=%0d perr=%0d good=%0d err=%0d",
                                 cyc, pkt_addr, pkt_len, parity_err, good_cnt, err_cnt);
                    end
                end
                if (pkt_drop) begin
                    if (drop_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL drop_unexpected actual=1 required 0 cyc=%0d", cyc);
                    end else begin
                        chk("drop_cyc", cyc, drop_q.pop_front());
                        exp_err = sat_inc(exp_err);
                        chk("err_cnt_drop", err_cnt, exp_err);
                        chk("good_cnt_drop", good_cnt, exp_good);
                        $display("pkt drop cyc=%0d good=%0d err=%0d", cyc, good_cnt, err_cnt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 2'd1, len: 6'd3, pld: 32'h00332211, flip: 1'b0, exp_good: 1, exp_err: 0};
        vecs[1] = '{addr: 2'd1, len: 6'd3, pld: 32'h00332211, flip: 1'b1, exp_good: 1, exp_err: 1};
        vecs[2] = '{addr: 2'd2, len: 6'd0, pld: 32'h00000000, flip: 1'b0, exp_good: 2, exp_err: 1};
        vecs[3] = '{addr: 2'd0, len: 6'd4, pld: 32'hf00f5aa5, flip: 1'b0, exp_good: 3, exp_err: 1};
        vecs[4] = '{addr: 2'd3, len: 6'd2, pld: 32'h00000180, flip: 1'b0, exp_good: 3, exp_err: 1};
        vecs[5] = '{addr: 2'd2, len: 6'd1, pld: 32'h000000ff, flip: 1'b1, exp_good: 3, exp_err: 2};

        repeat (3) @(negedge clk);
        chk("rst_read_enb", read_enb, 0);
        chk("rst_pld_valid", pld_valid, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_drop", pkt_drop, 0);
        chk("rst_pld_data", pld_data, 0);
        chk("rst_pkt_addr", pkt_addr, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_pkt(vecs[v].addr, vecs[v].len, vecs[v].pld, vecs[v].flip, 0);
            wait_done(40);
            chk("tbl_good_cnt", good_cnt, vecs[v].exp_good);
            chk("tbl_err_cnt", err_cnt, vecs[v].exp_err);
        end

        // Stall: FIFO looks empty for 3 cycles in mid-BODY.
        send_pkt(2'd1, 6'd3, 32'h00332211, 1'b0, 3);
        repeat (5) @(negedge clk);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_read_enb", read_enb, 0);
        end
        stall = 1'b0;
        wait_done(40);

        // Abort in the first BODY cycle; the FIFO is flushed with it.
        send_pkt(2'd2, 6'd3, 32'h00ccbbaa, 1'b0, 0);
        repeat (4) @(negedge clk);
        soft_reset = 1'b1;
        fifo.delete();
        pld_q.delete();
        done_q.delete();
        drop_q.push_back(cyc + 2);
        @(negedge clk);
        soft_reset = 1'b0;
        chk("abort_read_enb", read_enb, 0);
        wait_done(20);
        chk("abort_keep_addr", pkt_addr, 1);
        chk("abort_keep_len", pkt_len, 3);

        // Soft reset while idle must be ignored.
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_srst_err_cnt", err_cnt, exp_err);

        send_pkt(2'd3, 6'd2, 32'h00005544, 1'b0, 0);
        wait_done(40);

        // Asynchronous reset in the middle of a packet.
        send_pkt(2'd1, 6'd3, 32'h00332211, 1'b0, 0);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_read_enb", read_enb, 0);
        chk("mid_pld_valid", pld_valid, 0);
        chk("mid_pld_data", pld_data, 0);
        chk("mid_pkt_addr", pkt_addr, 0);
        chk("mid_pkt_len", pkt_len, 0);
        chk("mid_good_cnt", good_cnt, 0);
        chk("mid_err_cnt", err_cnt, 0);
        fifo.delete();
        pld_q.delete();
        done_q.delete();
        exp_good = 0;
        exp_err = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            send_pkt(2'(k), 6'd2, $urandom, 1'b0, 0);
            wait_done(40);
        end
        chk("sat_good_cnt", good_cnt, 3);
        chk("sat_err_cnt", err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
